// File: rtl/enemy_formation.sv
// Invader formation controller: alive mask, marching state machine, player-shot
// hit detection and registered per-pixel colour for the VGA OR-mixer.
module enemy_formation #(
  parameter int          ROWS        = 3,
  parameter int          COLS        = 8,
  parameter int          SPACING_X   = 48,
  parameter int          SPACING_Y   = 50,
  parameter int          SPRITE_W    = 32,
  parameter int          SPRITE_H    = 24,
  parameter int          X_START     = 180,
  parameter int          Y_START     = 40,
  parameter int          X_MIN       = 0,
  parameter int          X_MAX       = 639,
  parameter int          Y_LIMIT     = 400,
  parameter int          STEP_X      = 8,
  parameter int          STEP_Y      = 16,
  parameter int          SPEED_SHIFT = 2,
  parameter logic [23:0] COLOR       = 24'hFFFFFF
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           frame_tick,
  input  logic                           start,
  input  logic [9:0]                     h_counter,
  input  logic [9:0]                     v_counter,
  input  logic                           shot_valid,
  input  logic [10:0]                    shot_x,
  input  logic [10:0]                    shot_y,
  output logic                           hit,
  output logic [$clog2(ROWS*COLS)-1:0]   hit_id,
  output logic [ROWS*COLS-1:0]           alive,
  output logic [$clog2(ROWS*COLS+1)-1:0] alive_count,
  output logic                           all_dead,
  output logic                           reached_bottom,
  output logic [10:0]                    origin_x,
  output logic [10:0]                    origin_y,
  output logic [7:0]                     R,
  output logic [7:0]                     G,
  output logic [7:0]                     B
);

  localparam int N     = ROWS * COLS;
  localparam int ID_W  = $clog2(N);
  localparam int CNT_W = $clog2(N + 1);
  localparam int MC_W  = CNT_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MARCH_R,
    S_MARCH_L,
    S_DESCEND,
    S_HALTED
  } state_t;

  state_t            r_state, w_state_nxt;
  logic              r_dir, w_dir_nxt;  // 0: DESCEND came from MARCH_R
  logic [10:0]       r_origin_x, w_origin_x_nxt;
  logic [10:0]       r_origin_y, w_origin_y_nxt;
  logic [N-1:0]      r_alive, w_alive_nxt;
  logic [MC_W-1:0]   r_move_cnt, w_move_cnt_nxt;
  logic              r_hit, w_hit_nxt;
  logic [ID_W-1:0]   r_hit_id, w_hit_id_nxt;
  logic              r_all_dead, w_all_dead_nxt;
  logic              r_reached_bottom, w_reached_bottom_nxt;
  logic [7:0]        r_red, r_green, r_blue;

  logic [11:0]       w_ox, w_oy, w_sx, w_sy, w_hx, w_vy;
  logic [ROWS-1:0]   w_row_any;
  logic [COLS-1:0]   w_col_any;
  logic [11:0]       w_lc_off, w_rc_off, w_br_off;
  logic [CNT_W-1:0]  w_alive_count;
  logic [MC_W-1:0]   w_period;
  logic              w_active, w_move;
  logic              w_shot_hit;
  logic [ID_W-1:0]   w_shot_id;
  logic              w_pix_on;

  // All geometry is evaluated unsigned in 12 bits so subtraction-free left-edge tests never wrap.
  assign w_ox = {1'b0, r_origin_x};
  assign w_oy = {1'b0, r_origin_y};
  assign w_sx = {1'b0, shot_x};
  assign w_sy = {1'b0, shot_y};
  assign w_hx = {2'b00, h_counter};
  assign w_vy = {2'b00, v_counter};

  function automatic logic in_box(input logic [11:0] px, input logic [11:0] py,
                                  input logic [11:0] ox, input logic [11:0] oy,
                                  input int idx);
    logic [11:0] bx, by;
    bx = ox + 12'((idx % COLS) * SPACING_X);
    by = oy + 12'((idx / COLS) * SPACING_Y);
    return (px >= bx) && (px <= bx + 12'(SPRITE_W - 1)) &&
           (py >= by) && (py <= by + 12'(SPRITE_H - 1));
  endfunction

  // NOTE: every always_comb output gets a default first, otherwise a missed branch infers a latch.
  always_comb begin
    w_row_any     = '0;
    w_col_any     = '0;
    w_alive_count = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (r_alive[r*COLS + c]) begin
          w_row_any[r] = 1'b1;
          w_col_any[c] = 1'b1;
        end
        w_alive_count = w_alive_count + CNT_W'(r_alive[r*COLS + c]);
      end
    end
  end

  always_comb begin
    w_lc_off = '0;
    w_rc_off = '0;
    w_br_off = '0;
    for (int c = COLS - 1; c >= 0; c--)
      if (w_col_any[c]) w_lc_off = 12'(c * SPACING_X);
    for (int c = 0; c < COLS; c++)
      if (w_col_any[c]) w_rc_off = 12'(c * SPACING_X);
    for (int r = 0; r < ROWS; r++)
      if (w_row_any[r]) w_br_off = 12'(r * SPACING_Y);
  end

  // Descending scan leaves the lowest matching index as the winner.
  always_comb begin
    w_shot_hit = 1'b0;
    w_shot_id  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (r_alive[i] && in_box(w_sx, w_sy, w_ox, w_oy, i)) begin
        w_shot_hit = 1'b1;
        w_shot_id  = ID_W'(i);
      end
    end
  end

  always_comb begin
    w_pix_on = 1'b0;
    for (int i = 0; i < N; i++)
      if (r_alive[i] && in_box(w_hx, w_vy, w_ox, w_oy, i)) w_pix_on = 1'b1;
  end

  assign w_period = MC_W'(1) + MC_W'(w_alive_count >> SPEED_SHIFT);
  assign w_active = (r_state == S_MARCH_R) || (r_state == S_MARCH_L) || (r_state == S_DESCEND);

  always_comb begin
    w_state_nxt          = r_state;
    w_dir_nxt            = r_dir;
    w_origin_x_nxt       = r_origin_x;
    w_origin_y_nxt       = r_origin_y;
    w_alive_nxt          = r_alive;
    w_move_cnt_nxt       = r_move_cnt;
    w_hit_nxt            = 1'b0;
    w_hit_id_nxt         = r_hit_id;
    w_all_dead_nxt       = r_all_dead;
    w_reached_bottom_nxt = r_reached_bottom;
    w_move               = 1'b0;

    if (start) begin
      w_state_nxt          = S_MARCH_R;
      w_dir_nxt            = 1'b0;
      w_origin_x_nxt       = 11'(X_START);
      w_origin_y_nxt       = 11'(Y_START);
      w_alive_nxt          = '1;
      w_move_cnt_nxt       = '0;
      w_hit_id_nxt         = '0;
      w_all_dead_nxt       = 1'b0;
      w_reached_bottom_nxt = 1'b0;
    end else if (w_active) begin
      if (frame_tick) begin
        if (r_move_cnt + MC_W'(1) >= w_period) begin
          w_move_cnt_nxt = '0;
          w_move         = 1'b1;
        end else begin
          w_move_cnt_nxt = r_move_cnt + MC_W'(1);
        end
      end

      // Edge tests see the pre-hit live columns; the hit below sees the pre-move origin.
      if (w_move) begin
        case (r_state)
          S_MARCH_R: begin
            if (w_ox + w_rc_off + 12'(SPRITE_W - 1 + STEP_X) > 12'(X_MAX)) begin
              w_state_nxt = S_DESCEND;
              w_dir_nxt   = 1'b0;
            end else begin
              w_origin_x_nxt = 11'(w_ox + 12'(STEP_X));
            end
          end
          S_MARCH_L: begin
            if (w_ox + w_lc_off < 12'(X_MIN + STEP_X)) begin
              w_state_nxt = S_DESCEND;
              w_dir_nxt   = 1'b1;
            end else begin
              w_origin_x_nxt = 11'(w_ox - 12'(STEP_X));
            end
          end
          S_DESCEND: begin
            w_origin_y_nxt = 11'(w_oy + 12'(STEP_Y));
            w_state_nxt    = r_dir ? S_MARCH_R : S_MARCH_L;
            if ({1'b0, w_origin_y_nxt} + w_br_off + 12'(SPRITE_H - 1) >= 12'(Y_LIMIT)) begin
              w_reached_bottom_nxt = 1'b1;
              w_state_nxt          = S_HALTED;
            end
          end
          default: ;
        endcase
      end

      if (shot_valid && w_shot_hit) begin
        w_alive_nxt[w_shot_id] = 1'b0;
        w_hit_nxt              = 1'b1;
        w_hit_id_nxt           = w_shot_id;
        if (w_alive_nxt == '0) begin
          w_all_dead_nxt       = 1'b1;
          w_reached_bottom_nxt = r_reached_bottom;
          w_state_nxt          = S_HALTED;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state          <= S_IDLE;
      r_dir            <= 1'b0;
      r_origin_x       <= 11'(X_START);
      r_origin_y       <= 11'(Y_START);
      r_alive          <= '1;
      r_move_cnt       <= '0;
      r_hit            <= 1'b0;
      r_hit_id         <= '0;
      r_all_dead       <= 1'b0;
      r_reached_bottom <= 1'b0;
    end else begin
      r_state          <= w_state_nxt;
      r_dir            <= w_dir_nxt;
      r_origin_x       <= w_origin_x_nxt;
      r_origin_y       <= w_origin_y_nxt;
      r_alive          <= w_alive_nxt;
      r_move_cnt       <= w_move_cnt_nxt;
      r_hit            <= w_hit_nxt;
      r_hit_id         <= w_hit_id_nxt;
      r_all_dead       <= w_all_dead_nxt;
      r_reached_bottom <= w_reached_bottom_nxt;
    end
  end

  // One-clock pixel pipeline; the top level delays the other sprites to match.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_red   <= '0;
      r_green <= '0;
      r_blue  <= '0;
    end else begin
      r_red   <= w_pix_on ? COLOR[23:16] : 8'h00;
      r_green <= w_pix_on ? COLOR[15:8]  : 8'h00;
      r_blue  <= w_pix_on ? COLOR[7:0]   : 8'h00;
    end
  end

  assign hit            = r_hit;
  assign hit_id         = r_hit_id;
  assign alive          = r_alive;
  assign alive_count    = w_alive_count;
  assign all_dead       = r_all_dead;
  assign reached_bottom = r_reached_bottom;
  assign origin_x       = r_origin_x;
  assign origin_y       = r_origin_y;
  assign R              = r_red;
  assign G              = r_green;
  assign B              = r_blue;

endmodule

// File: tb/tb_enemy_formation.sv
// Directed bench for enemy_formation: marching, edges, hits, terminal flags
// and the pixel pipeline, with hand-computed expectations.
module tb_enemy_formation;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_tick = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  h_counter = '0;
  logic [9:0]  v_counter = '0;
  logic        shot_valid = 1'b0;
  logic [10:0] shot_x = '0;
  logic [10:0] shot_y = '0;
  logic        hit;
  logic [4:0]  hit_id;
  logic [23:0] alive;
  logic [4:0]  alive_count;
  logic        all_dead;
  logic        reached_bottom;
  logic [10:0] origin_x;
  logic [10:0] origin_y;
  logic [7:0]  R, G, B;

  int n_cmp = 0;
  int n_err = 0;

  enemy_formation dut (
    .clk            (clk),
    .reset          (reset),
    .frame_tick     (frame_tick),
    .start          (start),
    .h_counter      (h_counter),
    .v_counter      (v_counter),
    .shot_valid     (shot_valid),
    .shot_x         (shot_x),
    .shot_y         (shot_y),
    .hit            (hit),
    .hit_id         (hit_id),
    .alive          (alive),
    .alive_count    (alive_count),
    .all_dead       (all_dead),
    .reached_bottom (reached_bottom),
    .origin_x       (origin_x),
    .origin_y       (origin_y),
    .R              (R),
    .G              (G),
    .B              (B)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs set before this call are sampled at the edge; outputs are read 1 ns after it.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    frame_tick = 1'b1;
    repeat (n) cycle();
    frame_tick = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic shoot(input int x, input int y);
    shot_x     = 11'(x);
    shot_y     = 11'(y);
    shot_valid = 1'b1;
    cycle();
    shot_valid = 1'b0;
  endtask

  // Shot at the centre of enemy id for a formation whose origin is (ox, oy).
  task automatic kill(input int id, input int ox, input int oy);
    shoot(ox + (id % 8) * 48 + 16, oy + (id / 8) * 50 + 12);
    check($sformatf("kill%0d_hit", id), 32'(hit), 32'd1);
    check($sformatf("kill%0d_id", id), 32'(hit_id), 32'(id));
  endtask

  initial begin
    int pix_on;
    int pix_bad;
    logic exp_on;

    // Reset state
    #12;
    check("rst_origin_x", 32'(origin_x), 32'd180);
    check("rst_origin_y", 32'(origin_y), 32'd40);
    check("rst_alive", 32'(alive), 32'hFFFFFF);
    check("rst_count", 32'(alive_count), 32'd24);
    check("rst_hit", 32'(hit), 32'd0);
    check("rst_hit_id", 32'(hit_id), 32'd0);
    check("rst_flags", {30'd0, all_dead, reached_bottom}, 32'd0);
    check("rst_rgb", {8'd0, R, G, B}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // IDLE ignores ticks and shots
    ticks(10);
    shoot(196, 52);
    check("idle_origin", 32'(origin_x), 32'd180);
    check("idle_shot", 32'(hit), 32'd0);
    check("idle_alive", 32'(alive), 32'hFFFFFF);

    // 24 alive -> period 7; 11 steps to 268, then DESCEND, then y=56 and MARCH_L
    pulse_start();
    ticks(6);
    check("march_t6", 32'(origin_x), 32'd180);
    ticks(1);
    check("march_t7", 32'(origin_x), 32'd188);
    ticks(70);
    check("march_268", 32'(origin_x), 32'd268);
    ticks(7);
    check("enter_desc_x", 32'(origin_x), 32'd268);
    check("enter_desc_y", 32'(origin_y), 32'd40);
    ticks(7);
    check("desc_y", 32'(origin_y), 32'd56);
    ticks(7);
    check("march_l_x", 32'(origin_x), 32'd260);

    // start wins over a coincident hit
    start      = 1'b1;
    shot_x     = 11'd196;
    shot_y     = 11'd52;
    shot_valid = 1'b1;
    cycle();
    start      = 1'b0;
    shot_valid = 1'b0;
    check("start_wins_hit", 32'(hit), 32'd0);
    check("start_wins_alive", 32'(alive), 32'hFFFFFF);
    check("start_origin", {5'd0, origin_x, 5'd0, origin_y}, {5'd0, 11'd180, 5'd0, 11'd40});

    // Single hit at reset origin, then repeat and near-boundary shots
    shoot(196, 52);
    check("hit_pulse", 32'(hit), 32'd1);
    check("hit_id0", 32'(hit_id), 32'd0);
    check("hit_alive", 32'(alive), 32'hFFFFFE);
    check("hit_count", 32'(alive_count), 32'd23);
    cycle();
    check("hit_one_clk", 32'(hit), 32'd0);
    shoot(196, 52);
    check("dead_reshot", 32'(hit), 32'd0);
    shoot(260, 52);
    check("gap_shot", 32'(hit), 32'd0);
    shoot(259, 63);
    check("corner_hit", 32'(hit), 32'd1);
    check("corner_id", 32'(hit_id), 32'd1);
    check("corner_alive", 32'(alive), 32'hFFFFFC);

    // Column 7 removed -> 21 alive, period 6; right edge from column 6 allows 17 steps
    pulse_start();
    kill(7, 180, 40);
    kill(15, 180, 40);
    kill(23, 180, 40);
    check("col7_alive", 32'(alive), 32'h7F7F7F);
    ticks(102);
    check("col6_edge_x", 32'(origin_x), 32'd316);
    ticks(6);
    check("col6_desc_x", 32'(origin_x), 32'd316);
    check("col6_desc_y", 32'(origin_y), 32'd40);
    ticks(6);
    check("col6_desc_done", 32'(origin_y), 32'd56);

    // 20 kills -> 4 alive, period 2; then wipe out the rest
    pulse_start();
    for (int id = 0; id < 20; id++) kill(id, 180, 40);
    check("four_count", 32'(alive_count), 32'd4);
    check("four_alive", 32'(alive), 32'hF00000);
    ticks(1);
    check("period2_t1", 32'(origin_x), 32'd180);
    ticks(1);
    check("period2_t2", 32'(origin_x), 32'd188);
    for (int id = 20; id < 24; id++) kill(id, 188, 40);
    check("all_dead", 32'(all_dead), 32'd1);
    check("all_dead_alive", 32'(alive), 32'd0);
    check("all_dead_rb", 32'(reached_bottom), 32'd0);
    ticks(10);
    check("halted_frozen", 32'(origin_x), 32'd188);
    pulse_start();
    check("restart_alive", 32'(alive), 32'hFFFFFF);
    check("restart_flag", 32'(all_dead), 32'd0);
    ticks(7);
    check("restart_march", 32'(origin_x), 32'd188);

    // Unhindered march to the bottom: 15 descents, y=280, at the right edge
    pulse_start();
    frame_tick = 1'b1;
    for (int k = 0; k < 20000 && !reached_bottom; k++) cycle();
    frame_tick = 1'b0;
    check("bottom_flag", 32'(reached_bottom), 32'd1);
    check("bottom_y", 32'(origin_y), 32'd280);
    check("bottom_x", 32'(origin_x), 32'd268);
    shoot(284, 292);
    check("bottom_shot", 32'(hit), 32'd0);
    check("bottom_alive", 32'(alive), 32'hFFFFFF);
    ticks(20);
    check("bottom_frozen", {5'd0, origin_x, 5'd0, origin_y}, {5'd0, 11'd268, 5'd0, 11'd280});

    // Asynchronous reset out of HALTED
    #2;
    reset = 1'b1;
    #1;
    check("async_rb", 32'(reached_bottom), 32'd0);
    check("async_y", 32'(origin_y), 32'd40);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Pixel scan around enemy 0's box (180..211, 40..63) with one-clock latency
    pix_on  = 0;
    pix_bad = 0;
    for (int v = 30; v <= 70; v++) begin
      for (int h = 170; h <= 220; h++) begin
        h_counter = 10'(h);
        v_counter = 10'(v);
        cycle();
        exp_on = (h >= 180) && (h <= 211) && (v >= 40) && (v <= 63);
        if ({R, G, B} == 24'hFFFFFF) pix_on++;
        if ({R, G, B} != (exp_on ? 24'hFFFFFF : 24'h000000)) pix_bad++;
      end
    end
    check("pix_count", 32'(pix_on), 32'd768);
    check("pix_wrong", 32'(pix_bad), 32'd0);

    h_counter = 10'd190;
    v_counter = 10'd50;
    #1;
    check("pix_latency", {8'd0, R, G, B}, 32'd0);
    cycle();
    check("pix_on", {8'd0, R, G, B}, 32'hFFFFFF);
    reset = 1'b1;
    #1;
    check("pix_async_rst", {8'd0, R, G, B}, 32'd0);
    cycle();
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
